ps2_frame_rx_fifo: RTL and testbench

- Parametrised PS/2 device-to-host frame receiver. Successor to the single-byte mouse receiver.
- Adds input synchronisation, PS/2 clock deglitching, configurable data width, parity mode and timeout, and an output FIFO of received frames with per-entry error flags.
- Sits between the PS/2 pins and the mouse/keyboard protocol FSMs, so consumers no longer have to service every byte within one cycle.

---
 rtl/ps2_pkg.sv | 19 +
 rtl/ps2_line_filter.sv | 62 ++++++
 rtl/ps2_frame_rx_fifo.sv | 165 ++++++++++++++++
 tb/tb_ps2_frame_rx_fifo.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared constants and FSM encoding for the PS/2 receive/transmit blocks.
package ps2_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    localparam int ERR_PARITY_BIT = 0;
    localparam int ERR_STOP_BIT   = 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DATA   = 3'd1,
        ST_PARITY = 3'd2,
        ST_STOP   = 3'd3,
        ST_PUSH   = 3'd4
    } rx_state_e;

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 line conditioner: 2-FF synchronisers, clock deglitch filter and a
// one-cycle sample strobe issued in the cycle the filtered clock goes low.
module ps2_line_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic CLK,
    input  logic RESET,
    input  logic clk_ps2_in,
    input  logic data_ps2_in,
    output logic strobe,
    output logic data_sync
);
    localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic           clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
    logic           dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
    logic           flt_q, flt_d;
    logic           strobe_q, strobe_d;
    logic [FCW-1:0] cnt_q, cnt_d;

    always_comb begin
        clk_s1_d = clk_ps2_in;
        clk_s2_d = clk_s1_q;
        dat_s1_d = data_ps2_in;
        dat_s2_d = dat_s1_q;
        flt_d    = flt_q;
        cnt_d    = '0;
        // cnt_q counts how many consecutive samples already disagreed with flt_q
        if (clk_s2_q != flt_q) begin
            if (cnt_q == FCW'(FILTER_LEN - 1)) begin
                flt_d = clk_s2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        strobe_d = flt_q & ~flt_d;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
            flt_q    <= 1'b1;
            cnt_q    <= '0;
            strobe_q <= 1'b0;
        end else begin
            clk_s1_q <= clk_s1_d;
            clk_s2_q <= clk_s2_d;
            dat_s1_q <= dat_s1_d;
            dat_s2_q <= dat_s2_d;
            flt_q    <= flt_d;
            cnt_q    <= cnt_d;
            strobe_q <= strobe_d;
        end
    end

    assign strobe    = strobe_q;
    assign data_sync = dat_s2_q;

endmodule

// File: rtl/ps2_frame_rx_fifo.sv
// PS/2 device-to-host frame receiver with a show-ahead FIFO of {errors, data}.
// Latency: VALID is first high after the (FILTER_LEN+4)-th rising CLK edge that samples the stop-bit clock pin low.
module ps2_frame_rx_fifo
    import ps2_pkg::*;
#(
    parameter int DATA_BITS      = 8,
    parameter int PARITY_MODE    = 1,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int FILTER_LEN     = 4,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic                          CLK_PS2_IN,
    input  logic                          DATA_PS2_IN,
    input  logic                          READ_ENABLE,
    input  logic                          POP,
    output logic [DATA_BITS-1:0]          DATA_OUT,
    output logic [1:0]                    ERR_OUT,
    output logic                          VALID,
    output logic [$clog2(FIFO_DEPTH):0]   COUNT,
    output logic                          OVERFLOW,
    output logic                          FRAME_ABORT
);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int BCW = $clog2(DATA_BITS + 1);
    localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int EW  = DATA_BITS + 2;

    logic strobe, data_sync;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
        .CLK         (CLK),
        .RESET       (RESET),
        .clk_ps2_in  (CLK_PS2_IN),
        .data_ps2_in (DATA_PS2_IN),
        .strobe      (strobe),
        .data_sync   (data_sync)
    );

    rx_state_e            state_q, state_d;
    logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [1:0]           err_q, err_d;
    logic [TW-1:0]        to_q, to_d;
    logic                 abort_q, abort_d;
    logic                 push;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        err_d     = err_q;
        to_d      = '0;
        abort_d   = 1'b0;
        push      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (strobe && !data_sync && READ_ENABLE) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                    err_d     = '0;
                end
            end
            ST_DATA, ST_PARITY, ST_STOP: begin
                if (strobe) begin
                    if (state_q == ST_DATA) begin
                        shift_d   = {data_sync, shift_q[DATA_BITS-1:1]};
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == BCW'(DATA_BITS - 1))
                            state_d = (PARITY_MODE == PARITY_NONE) ? ST_STOP : ST_PARITY;
                    end else if (state_q == ST_PARITY) begin
                        // odd mode wants the XOR over data+parity to be 1, even mode 0
                        err_d[ERR_PARITY_BIT] = ((^shift_q) ^ data_sync) != (PARITY_MODE != PARITY_EVEN);
                        state_d = ST_STOP;
                    end else begin
                        err_d[ERR_STOP_BIT] = ~data_sync;
                        state_d = ST_PUSH;
                    end
                end else if (to_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                    abort_d = 1'b1;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            ST_PUSH: begin
                push    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            err_q     <= '0;
            to_q      <= '0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            err_q     <= err_d;
            to_q      <= to_d;
            abort_q   <= abort_d;
        end
    end

    // Frame FIFO; last_q keeps the most recently popped entry visible once empty.
    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [EW-1:0] last_q, last_d, head;
    logic          ovf_q, ovf_d;
    logic          pop_ok, push_ok, full;

    always_comb begin
        full     = (count_q == (AW+1)'(FIFO_DEPTH));
        pop_ok   = POP && (count_q != '0);
        push_ok  = push && (!full || pop_ok);
        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        ovf_d  = ovf_q | (push && !push_ok);
        last_d = pop_ok ? mem_q[rd_ptr_q] : last_q;
        head   = (count_q != '0) ? mem_q[rd_ptr_q] : last_q;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            last_q   <= last_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push_ok)
            mem_q[wr_ptr_q] <= {err_q, shift_q};
    end

    assign DATA_OUT    = head[DATA_BITS-1:0];
    assign ERR_OUT     = head[DATA_BITS +: 2];
    assign VALID       = (count_q != '0);
    assign COUNT       = count_q;
    assign OVERFLOW    = ovf_q;
    assign FRAME_ABORT = abort_q;

endmodule

// File: tb/tb_ps2_frame_rx_fifo.sv
// Bench for ps2_frame_rx_fifo: vector table, corner-case sequences and a
// randomized run scored against a queue-based model of the frame FIFO.
module tb_ps2_frame_rx_fifo;
    localparam int F     = 4;
    localparam int TO    = 200;
    localparam int DEPTH = 4;
    localparam int HALF  = 10;

    logic       CLK = 1'b0, RESET = 1'b1;
    logic       pclk = 1'b1, pdat = 1'b1, re = 1'b1, pop = 1'b0;
    logic [7:0] dout;
    logic [1:0] err;
    logic       valid, ovf, abort;
    logic [2:0] count;

    logic       np_pclk = 1'b1, np_pdat = 1'b1, np_pop = 1'b0;
    logic [7:0] np_dout;
    logic [1:0] np_err;
    logic       np_valid, np_ovf, np_abort;
    logic [2:0] np_count;

    int n_pass = 0, n_total = 0, abort_cnt = 0;

    logic [9:0] mq[$];
    logic [9:0] m_last = '0;
    bit         m_ovf = 0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) if (abort) abort_cnt <= abort_cnt + 1;

    ps2_frame_rx_fifo #(.DATA_BITS(8), .PARITY_MODE(1), .TIMEOUT_CYCLES(TO),
                        .FILTER_LEN(F), .FIFO_DEPTH(DEPTH)) dut (
        .CLK(CLK), .RESET(RESET), .CLK_PS2_IN(pclk), .DATA_PS2_IN(pdat),
        .READ_ENABLE(re), .POP(pop), .DATA_OUT(dout), .ERR_OUT(err),
        .VALID(valid), .COUNT(count), .OVERFLOW(ovf), .FRAME_ABORT(abort));

    ps2_frame_rx_fifo #(.DATA_BITS(8), .PARITY_MODE(0), .TIMEOUT_CYCLES(TO),
                        .FILTER_LEN(F), .FIFO_DEPTH(DEPTH)) dut_np (
        .CLK(CLK), .RESET(RESET), .CLK_PS2_IN(np_pclk), .DATA_PS2_IN(np_pdat),
        .READ_ENABLE(re), .POP(np_pop), .DATA_OUT(np_dout), .ERR_OUT(np_err),
        .VALID(np_valid), .COUNT(np_count), .OVERFLOW(np_ovf), .FRAME_ABORT(np_abort));

    typedef struct {
        logic [7:0] d;
        logic       par;
        logic       stp;
        logic [1:0] exp_err;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic odd_par(input logic [7:0] d);
        return ($countones(d) % 2) == 0;
    endfunction

    // mode: 0 plain, 1 measure cycles to VALID, 2 pop in the push cycle, 3 short glitch in high phase
    task automatic drive_bit(input bit sel, input logic b, input int mode, output int lat);
        lat = -1;
        @(negedge CLK);
        if (sel) np_pdat = b; else pdat = b;
        if (mode == 3) begin
            repeat (3) @(negedge CLK);
            pclk = 1'b0;
            repeat (F - 1) @(negedge CLK);
            pclk = 1'b1;
        end
        repeat (HALF) @(negedge CLK);
        if (sel) np_pclk = 1'b0; else pclk = 1'b0;
        if (mode == 1) begin
            for (int k = 1; k <= 2 * HALF; k++) begin
                @(posedge CLK); #1;
                if (valid && lat < 0) lat = k;
            end
        end else if (mode == 2) begin
            repeat (F + 3) @(posedge CLK);
            @(negedge CLK) pop = 1'b1;
            @(negedge CLK) pop = 1'b0;
        end
        repeat (HALF) @(negedge CLK);
        if (sel) np_pclk = 1'b1; else pclk = 1'b1;
    endtask

    task automatic send_partial(input logic [7:0] d, input int nbits);
        logic [10:0] b;
        int dl;
        b = {1'b1, odd_par(d), d, 1'b0};
        for (int i = 0; i < nbits; i++) drive_bit(1'b0, b[i], 0, dl);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                              input int mode, input bit glitch, output int lat);
        logic [10:0] b;
        int dl;
        b = {stp, par, d, 1'b0};
        for (int i = 0; i < 10; i++) drive_bit(1'b0, b[i], (glitch && i > 0) ? 3 : 0, dl);
        drive_bit(1'b0, b[10], mode, lat);
        repeat (2 * HALF) @(negedge CLK);
    endtask

    task automatic do_pop();
        @(negedge CLK) pop = 1'b1;
        @(negedge CLK) pop = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge CLK) RESET = 1'b1;
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
    endtask

    task automatic check_model(input string tag);
        logic [9:0] h;
        h = (mq.size() > 0) ? mq[0] : m_last;
        check({tag, "_count"}, count, mq.size());
        check({tag, "_valid"}, valid, mq.size() > 0);
        check({tag, "_ovf"}, ovf, m_ovf);
        check({tag, "_head"}, {err, dout}, h);
    endtask

    initial begin
        vec_t       tbl[6];
        int         lat, a0;
        logic [7:0] d;
        logic       par, stp;
        logic [9:0] nb, eh;

        tbl[0] = '{8'hA5, 1'b1, 1'b1, 2'b00};
        tbl[1] = '{8'h3C, 1'b0, 1'b1, 2'b01};
        tbl[2] = '{8'h3C, 1'b1, 1'b0, 2'b10};
        tbl[3] = '{8'h00, 1'b1, 1'b1, 2'b00};
        tbl[4] = '{8'hFF, 1'b0, 1'b0, 2'b11};
        tbl[5] = '{8'h80, 1'b0, 1'b1, 2'b00};

        repeat (4) @(negedge CLK);
        check("rst_dout", dout, 0);
        check("rst_err", err, 0);
        check("rst_valid", valid, 0);
        check("rst_count", count, 0);
        check("rst_ovf", ovf, 0);
        check("rst_abort", abort, 0);
        RESET = 1'b0;
        repeat (4) @(negedge CLK);

        for (int i = 0; i < 6; i++) begin
            send_frame(tbl[i].d, tbl[i].par, tbl[i].stp, 1, 1'b0, lat);
            check("tbl_latency", lat, F + 4);
            check("tbl_valid", valid, 1);
            check("tbl_dout", dout, tbl[i].d);
            check("tbl_err", err, tbl[i].exp_err);
            check("tbl_count", count, 1);
            do_pop();
            check("tbl_pop_valid", valid, 0);
            check("tbl_hold_dout", dout, tbl[i].d);
        end

        // no-parity build: start, 8 data bits, stop
        nb = {1'b1, 8'h81, 1'b0};
        for (int i = 0; i < 10; i++) drive_bit(1'b1, nb[i], 0, lat);
        repeat (2 * HALF) @(negedge CLK);
        check("np_valid", np_valid, 1);
        check("np_dout", np_dout, 8'h81);
        check("np_err", np_err, 0);
        check("np_count", np_count, 1);

        // timeout after start + 4 data bits
        a0 = abort_cnt;
        send_partial(8'h12, 5);
        repeat (TO + 50) @(negedge CLK);
        check("to_abort_pulses", abort_cnt - a0, 1);
        check("to_count", count, 0);
        send_frame(8'h12, odd_par(8'h12), 1'b1, 0, 1'b0, lat);
        check("to_next_dout", dout, 8'h12);
        check("to_next_err", err, 0);
        do_pop();

        // short clock glitches inside a frame must not add strobes
        send_frame(8'h5A, odd_par(8'h5A), 1'b1, 0, 1'b1, lat);
        check("glitch_dout", dout, 8'h5A);
        check("glitch_err", err, 0);
        check("glitch_count", count, 1);
        do_pop();

        // idle with data low: F-1 pulse ignored, F pulse is a start edge
        @(negedge CLK) pdat = 1'b0;
        repeat (HALF) @(negedge CLK);
        a0 = abort_cnt;
        pclk = 1'b0; repeat (F - 1) @(negedge CLK); pclk = 1'b1;
        repeat (TO + 50) @(negedge CLK);
        check("short_pulse_abort", abort_cnt - a0, 0);
        pclk = 1'b0; repeat (F) @(negedge CLK); pclk = 1'b1;
        repeat (TO + 50) @(negedge CLK);
        check("full_pulse_abort", abort_cnt - a0, 1);
        check("full_pulse_count", count, 0);
        pdat = 1'b1;

        // overflow
        do_reset();
        for (int i = 1; i <= 5; i++) send_frame(8'(i), odd_par(8'(i)), 1'b1, 0, 1'b0, lat);
        check("ovf_count", count, 4);
        check("ovf_flag", ovf, 1);
        for (int i = 1; i <= 4; i++) begin
            check("ovf_pop_dout", dout, i);
            do_pop();
        end
        check("ovf_drained", valid, 0);
        check("ovf_sticky", ovf, 1);

        // push and pop in the same cycle while full
        do_reset();
        for (int i = 1; i <= 4; i++) send_frame(8'(i), odd_par(8'(i)), 1'b1, 0, 1'b0, lat);
        check("full_count", count, 4);
        send_frame(8'h05, odd_par(8'h05), 1'b1, 2, 1'b0, lat);
        check("pushpop_count", count, 4);
        check("pushpop_ovf", ovf, 0);
        for (int i = 2; i <= 5; i++) begin
            check("pushpop_dout", dout, i);
            do_pop();
        end

        // reset mid-frame
        send_frame(8'h33, odd_par(8'h33), 1'b1, 0, 1'b0, lat);
        a0 = abort_cnt;
        send_partial(8'h77, 4);
        @(negedge CLK) RESET = 1'b1;
        @(negedge CLK) RESET = 1'b0;
        check("midrst_dout", dout, 0);
        check("midrst_err", err, 0);
        check("midrst_valid", valid, 0);
        check("midrst_count", count, 0);
        repeat (TO + 50) @(negedge CLK);
        check("midrst_no_abort", abort_cnt - a0, 0);
        send_frame(8'h77, odd_par(8'h77), 1'b1, 0, 1'b0, lat);
        check("after_rst_dout", dout, 8'h77);
        check("after_rst_err", err, 0);
        do_pop();

        // start bit with READ_ENABLE low
        re = 1'b0;
        send_frame(8'h00, odd_par(8'h00), 1'b1, 0, 1'b0, lat);
        check("re_off_count", count, 0);
        re = 1'b1;

        // randomized frames against the queue model
        do_reset();
        mq.delete();
        m_last = '0;
        m_ovf = 0;
        for (int n = 0; n < 40; n++) begin
            d   = 8'($urandom);
            par = odd_par(d) ^ ($urandom_range(0, 3) == 0);
            stp = ($urandom_range(0, 3) != 0);
            send_frame(d, par, stp, 0, 1'b0, lat);
            eh = {!stp, (($countones(d) + int'(par)) % 2) == 0, d};
            if (mq.size() < DEPTH) mq.push_back(eh);
            else m_ovf = 1;
            check_model("rnd");
            repeat ($urandom_range(0, 2)) begin
                do_pop();
                if (mq.size() > 0) m_last = mq.pop_front();
            end
            check_model("rnd_pop");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
